// File: rtl/adct_pkg.sv
// Shared ADCT timing constants and FSM state type, sized to match the CSR
// field widths of the ADCT control registers.
package adct_pkg;

  localparam int ADCT_PSC_W_PULS  = 23;
  localparam int ADCT_PSC_W_SRATE = 8;
  localparam int ADCT_DLY_W       = 9;
  localparam int ADCT_PW_W        = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } adct_state_e;

endpackage

// File: rtl/adct_psc.sv
// Loadable prescaler down-counter with phase-align (sync) and wrap detection.
// Produces a registered one-cycle strobe on each wrap; shared by PULS and SRATE channels.
module adct_psc
  import adct_pkg::*;
#(
  parameter int PSC_W = ADCT_PSC_W_SRATE
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_start,
  input  logic             i_active,
  input  logic             i_sync,
  input  logic [PSC_W-1:0] i_psc_div,
  output logic             o_stb,
  output logic             o_wrap
);

  logic [PSC_W-1:0] psc_cnt;

  assign o_wrap = i_active && (psc_cnt == '0);

  // A wrap always wins over sync so a sync landing on the wrap edge yields one strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      psc_cnt <= '0;
      o_stb   <= 1'b0;
    end else if (i_clear) begin
      psc_cnt <= '0;
      o_stb   <= 1'b0;
    end else if (i_start) begin
      psc_cnt <= i_psc_div;
      o_stb   <= 1'b0;
    end else if (o_wrap) begin
      psc_cnt <= i_psc_div;
      o_stb   <= 1'b1;
    end else if (i_active) begin
      psc_cnt <= i_sync ? '0 : psc_cnt - 1'b1;
      o_stb   <= 1'b0;
    end else begin
      o_stb   <= 1'b0;
    end
  end

endmodule

// File: rtl/adct_puls_timer.sv
// ADC trigger timing generator: prescaled period strobe followed by a delayed,
// programmable-width convert pulse. Delay and width are captured only at wrap.
module adct_puls_timer
  import adct_pkg::*;
#(
  parameter int PSC_W = ADCT_PSC_W_PULS,
  parameter int DLY_W = ADCT_DLY_W,
  parameter int PW_W  = ADCT_PW_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic [PSC_W-1:0] i_psc_div,
  input  logic [DLY_W-1:0] i_dly,
  input  logic [PW_W-1:0]  i_pwidth,
  output logic             o_stb,
  output logic             o_pulse,
  output logic             o_run
);

  adct_state_e      state;
  logic             wrap;
  logic [DLY_W-1:0] dly_cnt, dly_nxt;
  logic [PW_W-1:0]  pw_cnt, pw_nxt;
  logic [PW_W-1:0]  pw_hold, hold_nxt;

  adct_psc #(.PSC_W(PSC_W)) u_psc (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (!i_en),
    .i_start   ((state == IDLE) && i_en),
    .i_active  ((state == RUN) && i_en),
    .i_sync    (i_sync),
    .i_psc_div (i_psc_div),
    .o_stb     (o_stb),
    .o_wrap    (wrap)
  );

  // Wrap reloads the delay counter, which also cancels a delay about to expire;
  // any pulse load overrides the running width decrement (retrigger).
  always_comb begin
    dly_nxt  = dly_cnt;
    pw_nxt   = pw_cnt;
    hold_nxt = pw_hold;
    if (wrap) begin
      dly_nxt = i_dly;
      if (i_dly == '0) begin
        pw_nxt = i_pwidth;
      end else begin
        hold_nxt = i_pwidth;
        if (pw_cnt != '0) pw_nxt = pw_cnt - 1'b1;
      end
    end else begin
      if (dly_cnt != '0) dly_nxt = dly_cnt - 1'b1;
      if (dly_cnt == DLY_W'(1)) pw_nxt = pw_hold;
      else if (pw_cnt != '0) pw_nxt = pw_cnt - 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      o_run   <= 1'b0;
      dly_cnt <= '0;
      pw_cnt  <= '0;
      pw_hold <= '0;
      o_pulse <= 1'b0;
    end else if (!i_en) begin
      state   <= IDLE;
      o_run   <= 1'b0;
      dly_cnt <= '0;
      pw_cnt  <= '0;
      pw_hold <= '0;
      o_pulse <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= RUN;
          o_run <= 1'b1;
        end
        RUN: begin
          dly_cnt <= dly_nxt;
          pw_cnt  <= pw_nxt;
          pw_hold <= hold_nxt;
          o_pulse <= (pw_nxt != '0);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adct_puls_timer.sv
// Scoreboard bench for adct_puls_timer: stimulus queues per-cycle expected
// outputs, a monitor pops and compares them one time unit after each clock edge.
module tb_adct_puls_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        sync;
  logic [22:0] psc_div;
  logic [8:0]  dly;
  logic [15:0] pw;
  logic        stb, pulse, run;

  typedef struct {
    int   cyc;
    logic stb;
    logic pulse;
    logic run;
  } exp_t;

  exp_t sb_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  adct_puls_timer dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_en      (en),
    .i_sync    (sync),
    .i_psc_div (psc_div),
    .i_dly     (dly),
    .i_pwidth  (pw),
    .o_stb     (stb),
    .o_pulse   (pulse),
    .o_run     (run)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int c, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d got=%0b expected=%0b", name, c, act, exp);
    end
  endtask

  // Monitor: compare every queued expectation belonging to the cycle just clocked.
  always @(posedge clk) begin
    cyc++;
    #1;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      exp_t e;
      e = sb_q.pop_front();
      if (e.cyc < cyc) begin
        check_output("sb_missed", e.cyc, 1'b1, 1'b0);
      end else begin
        check_output("stb", cyc, stb, e.stb);
        check_output("pulse", cyc, pulse, e.pulse);
        check_output("run", cyc, run, e.run);
      end
    end
  end

  function automatic logic exp_stb(input int c, input int first, input int period);
    return (c >= first) && (((c - first) % period) == 0);
  endfunction

  function automatic logic exp_pulse(input int c, input int first, input int period,
                                     input int lo, input int width);
    return (width > 0) && (c >= first + lo) && (((c - first - lo) % period) < width);
  endfunction

  task automatic push(input int c, input logic s, input logic p, input logic r);
    exp_t e;
    e.cyc = c; e.stb = s; e.pulse = p; e.run = r;
    sb_q.push_back(e);
  endtask

  task automatic push_zero(input int start, input int len, input logic r);
    for (int c = start; c < start + len; c++) push(c, 1'b0, 1'b0, r);
  endtask

  task automatic push_window(input int start, input int len, input int first,
                             input int period, input int lo, input int width);
    for (int c = start; c < start + len; c++)
      push(c, exp_stb(c, first, period), exp_pulse(c, first, period, lo, width), 1'b1);
  endtask

  task automatic wait_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Drop enable for one edge, load a new configuration and re-enable.
  // r is the cycle in which o_run first reads 1.
  task automatic apply_stimulus(input int div, input int d, input int w, output int r);
    int n;
    n  = cyc;
    en = 1'b0;
    push(n + 1, 1'b0, 1'b0, 1'b0);
    wait_cycle(n + 1);
    psc_div = 23'(div);
    dly     = 9'(d);
    pw      = 16'(w);
    en      = 1'b1;
    r       = n + 2;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    rst = 1'b1; en = 1'b0; sync = 1'b0;
    psc_div = '0; dly = '0; pw = '0;

    // Reset, then idle with enable low (sync pulse must be ignored)
    push_zero(1, 105, 1'b0);
    wait_cycle(3);
    rst = 1'b0;
    wait_cycle(50);
    sync = 1'b1;
    wait_cycle(51);
    sync = 1'b0;
    wait_cycle(105);

    // Basic period: strobe every 10, pulse at stb+3 and stb+4
    apply_stimulus(9, 3, 2, r);
    push_window(r, 60, r + 10, 10, 3, 2);
    wait_cycle(r + 59);

    // Divider 0: strobe and pulse continuous, then width 0 kills the pulse
    apply_stimulus(0, 0, 1, r);
    push_window(r, 20, r + 1, 1, 0, 1);
    wait_cycle(r + 19);
    pw = 16'd0;
    push_window(r + 20, 10, r + 1, 1, 0, 0);
    wait_cycle(r + 29);

    // Delay equal to period: no pulse; delay 4 set mid-period applies at next wrap
    apply_stimulus(4, 5, 3, r);
    push_window(r, 30, r + 5, 5, 0, 0);
    wait_cycle(r + 27);
    dly = 9'd4;
    push_window(r + 30, 20, r + 30, 5, 4, 3);
    wait_cycle(r + 49);

    // Sync at count 40 re-phases the period; sync on a wrap edge is ignored
    apply_stimulus(99, 3, 2, r);
    push_window(r, 271, r + 61, 100, 3, 2);
    wait_cycle(r + 59);
    sync = 1'b1;
    wait_cycle(r + 60);
    sync = 1'b0;
    wait_cycle(r + 160);
    sync = 1'b1;
    wait_cycle(r + 161);
    sync = 1'b0;
    wait_cycle(r + 270);

    // Long pulse, disable at its 10th cycle (drop happens inside apply_stimulus)
    apply_stimulus(99, 0, 50, r);
    push_window(r, 110, r + 100, 100, 0, 50);
    wait_cycle(r + 109);

    // Same again, but async reset at the 10th pulse cycle
    apply_stimulus(99, 0, 50, r);
    push_window(r, 110, r + 100, 100, 0, 50);
    wait_cycle(r + 109);
    #2;
    rst = 1'b1;
    #1;
    check_output("async_rst_stb", cyc, stb, 1'b0);
    check_output("async_rst_pulse", cyc, pulse, 1'b0);
    check_output("async_rst_run", cyc, run, 1'b0);
    push_zero(r + 110, 2, 1'b0);
    wait_cycle(r + 111);
    rst = 1'b0;
    push_zero(r + 112, 4, 1'b1);
    wait_cycle(r + 115);
    en = 1'b0;
    push(r + 116, 1'b0, 1'b0, 1'b0);
    wait_cycle(r + 118);

    check_output("sb_drained", cyc, (sb_q.size() == 0), 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
